// File: rtl/sram_ctrl_pkg.sv
// Package sram_ctrl_pkg
//   Shared types and sizes for the 64x25 SRAM init controller.
//   - DEPTH/WIDTH/AW : array geometry (entries, bits per entry, address bits)
//   - state_t        : controller state (INIT sweep, RUN service)
//   - req_t          : address/data pair used for the array write port mux
//   Configuration macro: SRAM_CTRL_RESET_INIT_EN (enables the post-reset
//   zero sweep in the controller; see sram_init_ctrl_64x25).
package sram_ctrl_pkg;

  localparam int DEPTH = 64;
  localparam int WIDTH = 25;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data;
  } req_t;

endpackage

// File: rtl/sram_init_sweeper.sv
// Module sram_init_sweeper
//   Address counter that walks every array entry once after reset so the
//   controller can write zeros to each one.
//   Ports:
//     clock    in   controller clock
//     reset_n  in   synchronous active-low reset (restarts the sweep at 0)
//     en_i     in   sweep allowed (controller is in INIT)
//     we_o     out  sweep write strobe for this cycle
//     addr_o   out  entry being written this cycle
//     last_o   out  this cycle writes the final entry (DEPTH-1)
//   Only instantiated when SRAM_CTRL_RESET_INIT_EN is defined.
module sram_init_sweeper
  import sram_ctrl_pkg::*;
(
  input  logic          clock,
  input  logic          reset_n,
  input  logic          en_i,
  output logic          we_o,
  output logic [AW-1:0] addr_o,
  output logic          last_o
);

  // One extra bit so the count can step past DEPTH-1 without wrapping to 0.
  localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);

  logic [AW:0] cnt_q, cnt_d;
  logic        done_q, done_d;

  // Gated by reset_n so no write strobe escapes while reset is held.
  assign we_o   = en_i & ~done_q & reset_n;
  assign addr_o = cnt_q[AW-1:0];
  assign last_o = we_o & (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d  = cnt_q;
    done_d = done_q;
    if (we_o) begin
      cnt_d = cnt_q + 1'b1;
      if (last_o) done_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

endmodule

// File: rtl/sram_init_ctrl_64x25.sv
// Module sram_init_ctrl_64x25
//   Client-side controller for a 64x25 1R1W masked SRAM macro with a
//   one-cycle registered-address read.
//   Ports:
//     clock, reset_n                  clock, synchronous active-low reset
//     rreq_valid/ready/addr           client read request
//     rresp_valid, rresp_data         read response (pulse) and held data
//     wreq_valid/ready/addr/data      client write request
//     init_done                       array contents defined
//     arr_r_en/addr, arr_r_data       array read port
//     arr_w_en/addr/data/mask         array write port
//   Configuration macro: SRAM_CTRL_RESET_INIT_EN
//     defined   - after reset every entry is written to zero before the
//                 client ports open (DEPTH cycles).
//     undefined - ports open on the first cycle after reset release,
//                 array contents undefined until written.
module sram_init_ctrl_64x25
  import sram_ctrl_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             rreq_valid,
  output logic             rreq_ready,
  input  logic [AW-1:0]    rreq_addr,
  output logic             rresp_valid,
  output logic [WIDTH-1:0] rresp_data,
  input  logic             wreq_valid,
  output logic             wreq_ready,
  input  logic [AW-1:0]    wreq_addr,
  input  logic [WIDTH-1:0] wreq_data,
  output logic             init_done,
  output logic             arr_r_en,
  output logic [AW-1:0]    arr_r_addr,
  input  logic [WIDTH-1:0] arr_r_data,
  output logic             arr_w_en,
  output logic [AW-1:0]    arr_w_addr,
  output logic [WIDTH-1:0] arr_w_data,
  output logic             arr_w_mask
);

  state_t           state_q;
  logic             init_done_q;
  logic             rd_pend_q;
  logic             byp_q;
  logic [WIDTH-1:0] byp_data_q;
  logic [WIDTH-1:0] hold_q;

  logic             sweep_we;
  logic             sweep_last;
  logic [AW-1:0]    sweep_addr;
  logic             rd_acc;
  logic             wr_acc;
  logic [WIDTH-1:0] rd_data;
  req_t             wr_req;

`ifdef SRAM_CTRL_RESET_INIT_EN
  localparam state_t RESET_STATE = INIT;

  sram_init_sweeper u_sweeper (
    .clock   (clock),
    .reset_n (reset_n),
    .en_i    (state_q == INIT),
    .we_o    (sweep_we),
    .addr_o  (sweep_addr),
    .last_o  (sweep_last)
  );
`else
  localparam state_t RESET_STATE = RUN;

  assign sweep_we   = 1'b0;
  assign sweep_last = 1'b0;
  assign sweep_addr = '0;
`endif

  // Both ports open together once the array is defined.
  assign rreq_ready = (state_q == RUN) & init_done_q;
  assign wreq_ready = (state_q == RUN) & init_done_q;
  assign init_done  = init_done_q;

  assign rd_acc = rreq_valid & rreq_ready;
  assign wr_acc = wreq_valid & wreq_ready;

  assign arr_r_en   = rd_acc;
  assign arr_r_addr = rreq_addr;

  always_comb begin
    wr_req = '{addr: wreq_addr, data: wreq_data};
    if (sweep_we) wr_req = '{addr: sweep_addr, data: '0};
  end

  assign arr_w_en   = sweep_we | wr_acc;
  assign arr_w_addr = wr_req.addr;
  assign arr_w_data = wr_req.data;
  assign arr_w_mask = arr_w_en;

  // A same-address write in the read cycle wins over the array output,
  // since the macro does not define read-during-write behaviour.
  assign rd_data     = byp_q ? byp_data_q : arr_r_data;
  assign rresp_valid = rd_pend_q;
  assign rresp_data  = rd_pend_q ? rd_data : hold_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= RESET_STATE;
      init_done_q <= 1'b0;
      rd_pend_q   <= 1'b0;
      byp_q       <= 1'b0;
      hold_q      <= '0;
    end else begin
      rd_pend_q <= rd_acc;
      byp_q     <= rd_acc & wr_acc & (rreq_addr == wreq_addr);
      if (rd_pend_q) hold_q <= rd_data;
      case (state_q)
        INIT: begin
          if (sweep_last) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end
        end
        RUN: init_done_q <= 1'b1;
      endcase
    end
  end

  // Bypass data only matters when byp_q is set, so it needs no reset.
  always_ff @(posedge clock) begin
    if (wr_acc) byp_data_q <= wreq_data;
  end

endmodule

// File: tb/tb_sram_init_ctrl_64x25.sv
module tb_sram_init_ctrl_64x25;

  logic        clock;
  logic        reset_n;
  logic        rreq_valid;
  logic        rreq_ready;
  logic [5:0]  rreq_addr;
  logic        rresp_valid;
  logic [24:0] rresp_data;
  logic        wreq_valid;
  logic        wreq_ready;
  logic [5:0]  wreq_addr;
  logic [24:0] wreq_data;
  logic        init_done;
  logic        arr_r_en;
  logic [5:0]  arr_r_addr;
  logic [24:0] arr_r_data;
  logic        arr_w_en;
  logic [5:0]  arr_w_addr;
  logic [24:0] arr_w_data;
  logic        arr_w_mask;

  sram_init_ctrl_64x25 dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rreq_valid  (rreq_valid),
    .rreq_ready  (rreq_ready),
    .rreq_addr   (rreq_addr),
    .rresp_valid (rresp_valid),
    .rresp_data  (rresp_data),
    .wreq_valid  (wreq_valid),
    .wreq_ready  (wreq_ready),
    .wreq_addr   (wreq_addr),
    .wreq_data   (wreq_data),
    .init_done   (init_done),
    .arr_r_en    (arr_r_en),
    .arr_r_addr  (arr_r_addr),
    .arr_r_data  (arr_r_data),
    .arr_w_en    (arr_w_en),
    .arr_w_addr  (arr_w_addr),
    .arr_w_data  (arr_w_data),
    .arr_w_mask  (arr_w_mask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Array macro model: registered-address read returning pre-write contents,
  // filled with garbage on the first edge so a missing sweep is visible.
  logic [24:0] tb_mem [64];
  logic [24:0] arr_rd_q;
  bit          mem_filled;

  always @(posedge clock) begin
    if (!mem_filled) begin
      for (int i = 0; i < 64; i++) tb_mem[i] <= 25'($urandom);
      mem_filled <= 1'b1;
    end else if (arr_w_en && arr_w_mask) begin
      tb_mem[arr_w_addr] <= arr_w_data;
    end
    if (arr_r_en) arr_rd_q <= tb_mem[arr_r_addr];
  end
  assign arr_r_data = arr_rd_q;

  // Reference model: client-visible contents plus expected response.
  logic [24:0] ref_mem [64];
  bit          mdl_ready;
  bit          exp_v;
  logic [24:0] exp_d;

  int n_tests;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One client cycle: drive at the negedge, check strobes, update the model,
  // then check the response at the following negedge.
  task automatic step(input bit rv, input logic [5:0] ra, input bit wv,
                      input logic [5:0] wa, input logic [24:0] wd);
    bit racc;
    bit wacc;
    rreq_valid = rv; rreq_addr = ra;
    wreq_valid = wv; wreq_addr = wa; wreq_data = wd;
    #1;
    racc = rv && mdl_ready;
    wacc = wv && mdl_ready;
    chk("rreq_ready", rreq_ready, mdl_ready);
    chk("wreq_ready", wreq_ready, mdl_ready);
    chk("arr_r_en", arr_r_en, racc);
    chk("arr_w_en", arr_w_en, wacc);
    if (racc) chk("arr_r_addr", arr_r_addr, ra);
    if (wacc) begin
      chk("arr_w_addr", arr_w_addr, wa);
      chk("arr_w_data", arr_w_data, wd);
      chk("arr_w_mask", arr_w_mask, 1);
    end
    if (racc) begin
      exp_v = 1'b1;
      exp_d = (wacc && wa == ra) ? wd : ref_mem[ra];
    end else begin
      exp_v = 1'b0;
    end
    if (wacc) ref_mem[wa] = wd;
    @(negedge clock);
    rreq_valid = 1'b0;
    wreq_valid = 1'b0;
    chk("rresp_valid", rresp_valid, exp_v);
    chk("rresp_data", rresp_data, exp_d);
  endtask

  // Called at a negedge right after reset_n is driven high.
  task automatic sweep_check();
    int  n_wr;
    bit  done_seen;
    n_wr = 0;
    done_seen = 1'b0;
    for (int c = 0; c < 200 && !done_seen; c++) begin
      #1;
      if (init_done) begin
        done_seen = 1'b1;
        chk("sweep_done_cycle", c, 64);
      end else begin
        chk("sweep_ready", {rreq_ready, wreq_ready}, 0);
        chk("sweep_rresp_valid", rresp_valid, 0);
        if (arr_w_en) begin
          chk("sweep_addr", arr_w_addr, n_wr);
          chk("sweep_data", arr_w_data, 0);
          chk("sweep_mask", arr_w_mask, 1);
          n_wr++;
        end
        @(negedge clock);
      end
    end
    chk("sweep_done_seen", done_seen, 1);
    chk("sweep_writes", n_wr, 64);
  endtask

  // Release reset (called at a negedge with reset held) and wait until open.
  task automatic bring_up();
    reset_n = 1'b1;
`ifdef SRAM_CTRL_RESET_INIT_EN
    sweep_check();
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
`else
    #1;
    chk("init_done_before_edge", init_done, 0);
    @(negedge clock);
    chk("init_done_after_release", init_done, 1);
    chk("ready_after_release", {rreq_ready, wreq_ready}, 2'b11);
    for (int i = 0; i < 3; i++) begin
      chk("idle_no_write", arr_w_en, 0);
      @(negedge clock);
    end
`endif
    mdl_ready = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    mdl_ready = 1'b0;
    exp_v = 1'b0;
    exp_d = '0;
    reset_n = 1'b0;
    rreq_valid = 1'b0; rreq_addr = '0;
    wreq_valid = 1'b0; wreq_addr = '0; wreq_data = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;

    repeat (3) @(negedge clock);
    chk("rst_rresp_valid", rresp_valid, 0);
    chk("rst_rresp_data", rresp_data, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_arr_w_en", arr_w_en, 0);
    chk("rst_arr_r_en", arr_r_en, 0);
    chk("rst_ready", {rreq_ready, wreq_ready}, 0);

`ifdef SRAM_CTRL_RESET_INIT_EN
    // Interrupt the first sweep at address 30; it must restart from 0.
    begin
      bit hit;
      hit = 1'b0;
      reset_n = 1'b1;
      for (int c = 0; c < 100 && !hit; c++) begin
        #1;
        if (arr_w_en && arr_w_addr == 6'd30) hit = 1'b1;
        else @(negedge clock);
      end
      chk("sweep_reached_30", hit, 1);
      reset_n = 1'b0;
      @(negedge clock);
      chk("midsweep_rst_w_en", arr_w_en, 0);
      chk("midsweep_rst_init_done", init_done, 0);
      chk("midsweep_rst_rresp_valid", rresp_valid, 0);
    end
`endif
    bring_up();
`ifndef SRAM_CTRL_RESET_INIT_EN
    for (int a = 0; a < 64; a++) step(1'b0, '0, 1'b1, 6'(a), '0);
`endif

    // Write then read next cycle.
    step(1'b0, '0, 1'b1, 6'd5, 25'h1ABCDEF);
    step(1'b1, 6'd5, 1'b0, '0, '0);
    chk("dir_read5_valid", rresp_valid, 1);
    chk("dir_read5_data", rresp_data, 25'h1ABCDEF);

    // Same-cycle write/read bypass, and a different-address read.
    step(1'b1, 6'd9, 1'b1, 6'd9, 25'h0000123);
    chk("dir_bypass9", rresp_data, 25'h0000123);
    step(1'b1, 6'd10, 1'b1, 6'd9, 25'h0000123);
    chk("dir_read10", rresp_data, 25'h0);

    // Held data ignores a later write to the same address.
    step(1'b0, '0, 1'b1, 6'd3, 25'h7);
    step(1'b1, 6'd3, 1'b0, '0, '0);
    chk("dir_read3", rresp_data, 25'h7);
    step(1'b0, '0, 1'b1, 6'd3, 25'h55);
    chk("dir_hold3_valid", rresp_valid, 0);
    chk("dir_hold3_data", rresp_data, 25'h7);
    step(1'b0, '0, 1'b0, '0, '0);
    chk("dir_hold3_idle", rresp_data, 25'h7);
    step(1'b1, 6'd3, 1'b0, '0, '0);
    chk("dir_reread3", rresp_data, 25'h55);

    // Randomized traffic over a small address window to force collisions.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 25'($urandom));
    end

    // Reset while a read is being accepted: response must be dropped.
    rreq_valid = 1'b1;
    rreq_addr  = 6'd5;
    reset_n    = 1'b0;
    @(negedge clock);
    rreq_valid = 1'b0;
    chk("midread_rst_rresp_valid", rresp_valid, 0);
    chk("midread_rst_rresp_data", rresp_data, 0);
    chk("midread_rst_init_done", init_done, 0);
    mdl_ready = 1'b0;
    exp_v = 1'b0;
    exp_d = '0;
    bring_up();
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 6'($urandom_range(0, 7)), 25'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
